square_rasterizer: RTL and testbench

Downstream pixel stage between the square-sequencing FSM and the VGA adapter. It accepts square draw requests (top-left x, y and colour) through a valid/ready handshake and buffers them in a small FIFO. It expands each request into SIZE×SIZE single-pixel writes, one pixel per clock, on the adapter's x/y/colour/plot port, clipped to the 160×120 screen.

---
 rtl/square_rasterizer_pkg.sv | 19 +
 rtl/square_req_fifo.sv | 40 ++++
 rtl/square_rasterizer.sv | 84 ++++++++
 tb/tb_square_rasterizer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/square_rasterizer_pkg.sv
// square_rasterizer_pkg: shared colours, screen limits, coordinate widths and request type
package square_rasterizer_pkg;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam logic [C_W-1:0] BLACK  = 3'b000;
  localparam logic [C_W-1:0] RED    = 3'b100;
  localparam logic [C_W-1:0] YELLOW = 3'b110;
  localparam logic [C_W-1:0] GREEN  = 3'b010;
  localparam logic [C_W-1:0] BLUE   = 3'b001;
  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] colour;
  } req_t;
  typedef enum logic {IDLE, DRAW} state_t;
endpackage

// File: rtl/square_req_fifo.sv
// square_req_fifo: synchronous DEPTH-entry request FIFO, pushes refused while full
module square_req_fifo
  import square_rasterizer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  req_t din,
  output req_t dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  req_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  // storage array, no reset needed since cnt guards reads
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  // pointers and occupancy
  always_ff @(posedge clk)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/square_rasterizer.sv
// square_rasterizer: expands queued square requests into clipped one-pixel-per-clock writes (SQUARE_OUTLINE_EN draws outlines only)
module square_rasterizer
  import square_rasterizer_pkg::*;
#(
  parameter int SIZE = 4,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_x,
  input  logic [6:0] req_y,
  input  logic [2:0] req_colour,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);
  localparam int CW = $clog2(SIZE);
  localparam logic [CW-1:0] LAST = CW'(SIZE-1);
  req_t din, head, work;
  state_t state;
  logic [CW-1:0] cx, cy;
  logic full, empty, push, pop, last, draw, on_screen;
  logic [X_W-1:0] px;
  logic [Y_W-1:0] py;
  assign din = {req_x, req_y, req_colour};
  assign req_ready = !full;
  assign push = req_valid && !full;
  assign last = cx == LAST && cy == LAST;
  assign pop = !empty && (state == IDLE || last);
  assign draw = state == DRAW;
  assign busy = draw || !empty;
  assign px = work.x + X_W'(cx);
  assign py = work.y + Y_W'(cy);
  assign on_screen = px < X_W'(SCREEN_W) && py < Y_W'(SCREEN_H);
  assign vga_x = draw ? px : '0;
  assign vga_y = draw ? py : '0;
  assign vga_colour = draw ? work.colour : '0;
`ifdef SQUARE_OUTLINE_EN
  logic border;
  assign border = cx == '0 || cx == LAST || cy == '0 || cy == LAST;
  assign vga_plot = draw && on_screen && border;
`else
  assign vga_plot = draw && on_screen;
`endif
  square_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(din),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  // sequencer: reloads on pop so consecutive squares run with no bubble
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cx <= '0;
      cy <= '0;
      done <= 1'b0;
      work <= '0;
    end else begin
      done <= draw && last;
      if (pop) begin
        work <= head;
        cx <= '0;
        cy <= '0;
        state <= DRAW;
      end else if (draw && last) begin
        cx <= '0;
        cy <= '0;
        state <= IDLE;
      end else if (draw) begin
        cx <= cx == LAST ? '0 : cx + 1'b1;
        cy <= cx == LAST ? cy + 1'b1 : cy;
      end
    end
endmodule

// File: tb/tb_square_rasterizer.sv
// tb_square_rasterizer: scoreboard bench for square_rasterizer (SIZE=4, DEPTH=4)
module tb_square_rasterizer;
  import square_rasterizer_pkg::*;
  localparam int SIZE = 4;
  logic clk = 0, reset = 1, req_valid = 0;
  logic [7:0] req_x = 0;
  logic [6:0] req_y = 0;
  logic [2:0] req_colour = 0;
  logic req_ready, vga_plot, busy, done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  int total = 0, bad = 0, cyc = 0;
  int plot_cnt, first_plot, last_plot, done_cnt;
  int done_q[$];
  int hs_q[$];
  logic [17:0] exp_q[$];

  square_rasterizer #(.SIZE(SIZE), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (!reset) begin
      if (vga_plot) begin
        plot_cnt++;
        if (first_plot < 0) first_plot = cyc;
        last_plot = cyc;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL pixel_extra got (%0d,%0d,%0d) required none", vga_x, vga_y, vga_colour);
        end else begin
          logic [17:0] e;
          e = exp_q.pop_front();
          if ({vga_x, vga_y, vga_colour} !== e) begin
            bad++;
            $display("FAIL pixel got (%0d,%0d,%0d) required (%0d,%0d,%0d)",
                     vga_x, vga_y, vga_colour, e[17:10], e[9:3], e[2:0]);
          end
        end
      end
      if (done) begin
        done_cnt++;
        done_q.push_back(cyc);
      end
    end

  task clear_stats();
    plot_cnt = 0; first_plot = -1; last_plot = -1; done_cnt = 0;
    done_q.delete(); hs_q.delete();
  endtask

  task send(input int x, input int y, input logic [2:0] c);
    int n;
    int px, py;
    logic on;
    req_x = 8'(x); req_y = 7'(y); req_colour = c; req_valid = 1;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!req_ready) begin
      bad++;
      $display("FAIL accept_timeout got ready=0 required 1");
    end
    @(posedge clk);
    #1 hs_q.push_back(cyc);
    for (int r = 0; r < SIZE; r++)
      for (int k = 0; k < SIZE; k++) begin
        px = (x + k) % 256;
        py = (y + r) % 128;
        on = px < SCREEN_W && py < SCREEN_H;
`ifdef SQUARE_OUTLINE_EN
        on = on && (k == 0 || k == SIZE-1 || r == 0 || r == SIZE-1);
`endif
        if (on) exp_q.push_back({8'(px), 7'(py), c});
      end
    @(negedge clk);
    req_valid = 0;
  endtask

  task drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) break;
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task test_reset();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got %0b required 1", req_ready); end
    total++; if ({vga_x, vga_y, vga_colour} !== 18'd0) begin bad++; $display("FAIL rst_pixel got %0h required 0", {vga_x, vga_y, vga_colour}); end
    total++; if (vga_plot !== 1'b0) begin bad++; $display("FAIL rst_plot got %0b required 0", vga_plot); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %0b required 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got %0b required 0", done); end
  endtask

  task test_single();
    int h;
    clear_stats();
    send(10, 112, RED);
    h = hs_q[0];
    total++; if (vga_plot !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL single_gap got plot=%0b busy=%0b required plot=0 busy=1", vga_plot, busy); end
    drain();
    total++; if (plot_cnt != 16) begin bad++; $display("FAIL single_count got %0d required 16", plot_cnt); end
    total++; if (first_plot != h + 1 || last_plot != h + 16) begin bad++; $display("FAIL single_window got %0d..%0d required %0d..%0d", first_plot, last_plot, h + 1, h + 16); end
    total++; if (done_cnt != 1 || done_q[0] != h + 17) begin bad++; $display("FAIL single_done got n=%0d at %0d required 1 at %0d", done_cnt, done_cnt ? done_q[0] : -1, h + 17); end
    total++; if (busy !== 1'b0 || exp_q.size() != 0) begin bad++; $display("FAIL single_end got busy=%0b left=%0d required 0 0", busy, exp_q.size()); end
  endtask

  task test_back_to_back();
    clear_stats();
    send(10, 20, BLUE);
    send(20, 20, GREEN);
    send(30, 20, YELLOW);
    drain();
    total++; if (plot_cnt != 48 || last_plot - first_plot != 47) begin bad++; $display("FAIL b2b_contig got n=%0d span=%0d required 48 47", plot_cnt, last_plot - first_plot); end
    total++; if (done_cnt != 3) begin bad++; $display("FAIL b2b_done_cnt got %0d required 3", done_cnt); end
    else begin
      total++; if (done_q[1] - done_q[0] != 16 || done_q[2] - done_q[1] != 16) begin bad++; $display("FAIL b2b_done_gap got %0d,%0d required 16,16", done_q[1] - done_q[0], done_q[2] - done_q[1]); end
    end
  endtask

  task test_full();
    clear_stats();
    for (int i = 0; i < 5; i++) send(i * 20, 40, RED);
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL full_ready got %0b required 0", req_ready); end
    send(100, 60, BLUE);
    total++; if (hs_q[4] - hs_q[0] != 4 || hs_q[5] - hs_q[0] != 18) begin bad++; $display("FAIL full_accepts got +%0d,+%0d required +4,+18", hs_q[4] - hs_q[0], hs_q[5] - hs_q[0]); end
    drain();
    total++; if (plot_cnt != 96 || done_cnt != 6) begin bad++; $display("FAIL full_drawn got plots=%0d dones=%0d required 96 6", plot_cnt, done_cnt); end
  endtask

  task test_clip();
    clear_stats();
    send(158, 118, YELLOW);
    drain();
    total++; if (plot_cnt != 4) begin bad++; $display("FAIL clip_count got %0d required 4", plot_cnt); end
    total++; if (done_cnt != 1 || exp_q.size() != 0) begin bad++; $display("FAIL clip_done got dones=%0d left=%0d required 1 0", done_cnt, exp_q.size()); end
  endtask

  task test_reset_mid();
    send(60, 30, RED);
    send(70, 30, GREEN);
    send(80, 30, BLUE);
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    total++; if (vga_plot !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL midrst_state got plot=%0b busy=%0b ready=%0b done=%0b required 0 0 1 0", vga_plot, busy, req_ready, done); end
    reset = 0;
    exp_q.delete();
    clear_stats();
    repeat (40) @(negedge clk);
    total++; if (plot_cnt != 0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_quiet got plots=%0d busy=%0b required 0 0", plot_cnt, busy); end
  endtask

  task test_outline();
    int want;
`ifdef SQUARE_OUTLINE_EN
    want = 12;
`else
    want = 16;
`endif
    clear_stats();
    send(40, 50, GREEN);
    drain();
    total++; if (plot_cnt != want) begin bad++; $display("FAIL outline_count got %0d required %0d", plot_cnt, want); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL outline_left got %0d required 0", exp_q.size()); end
  endtask

  initial begin
    clear_stats();
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_clip();
    test_reset_mid();
    test_outline();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
